// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Encodings shared by the UART transmit and receive front ends.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Bit 1 enables parity, bit 0 selects odd.
    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b10;
    localparam logic [1:0] PARITY_ODD  = 2'b11;

    localparam logic DS_8BIT = 1'b0;
    localparam logic DS_7BIT = 1'b1;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/baud_timer.sv
`default_nettype none
// ============================================================================
//  Module   : baud_timer
//  Purpose  : 16-bit loadable down-counter; tick_o marks the last cycle of a bit.
//  Revision : 1.0 - initial release
// ============================================================================
module baud_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        en_i,
    output logic        tick_o
);

    logic [15:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= 16'd0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (en_i && (r_count != 16'd0)) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign tick_o = (r_count == 16'd0);

endmodule
`default_nettype wire

// File: rtl/tx_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tx_frontend
//  Purpose  : UART transmitter: start, 7/8 data bits LSB first, parity, stop.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_frontend (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] cr_clk_div_i,
    input  logic        cr_ds_i,
    input  logic [1:0]  cr_p_i,
    input  logic        cr_s_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        uart_tx_o
);

    import uart_pkg::*;

    uart_state_t r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic        r_parity;
    logic [15:0] r_div_m1;
    logic        r_ds;
    logic [1:0]  r_p;
    logic        r_s;
    logic        r_second_stop;
    logic        r_tx;

    logic        w_tick;
    logic        w_accept;
    logic        w_last_stop;
    logic        w_last_data;
    logic        w_ready;
    logic        w_timer_load;
    logic [15:0] w_eff_div_m1;
    logic [15:0] w_timer_val;

    // A divider of 0 behaves like 1, so both give a reload value of 0.
    assign w_eff_div_m1 = (cr_clk_div_i == 16'd0) ? 16'd0 : (cr_clk_div_i - 16'd1);

    assign w_last_stop = (r_state == ST_STOP) && w_tick && ((r_s == STOP_1) || r_second_stop);
    assign w_last_data = (r_bit_idx == ((r_ds == DS_7BIT) ? 3'd6 : 3'd7));
    assign w_ready     = (r_state == ST_IDLE) || w_last_stop;
    assign w_accept    = valid_i && w_ready;

    assign w_timer_load = w_accept || ((r_state != ST_IDLE) && w_tick);
    assign w_timer_val  = w_accept ? w_eff_div_m1 : r_div_m1;

    baud_timer u_baud_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_timer_load),
        .load_val_i (w_timer_val),
        .en_i       (r_state != ST_IDLE),
        .tick_o     (w_tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_shift       <= 8'd0;
            r_bit_idx     <= 3'd0;
            r_parity      <= 1'b0;
            r_div_m1      <= 16'd0;
            r_ds          <= DS_8BIT;
            r_p           <= PARITY_NONE;
            r_s           <= STOP_1;
            r_second_stop <= 1'b0;
            r_tx          <= 1'b1;
        end else if (w_accept) begin
            // Acceptance in the final stop cycle chains straight into a new start bit.
            r_state       <= ST_START;
            r_shift       <= data_i;
            r_bit_idx     <= 3'd0;
            r_parity      <= 1'b0;
            r_div_m1      <= w_eff_div_m1;
            r_ds          <= cr_ds_i;
            r_p           <= cr_p_i;
            r_s           <= cr_s_i;
            r_second_stop <= 1'b0;
            r_tx          <= 1'b0;
        end else if ((r_state != ST_IDLE) && w_tick) begin
            case (r_state)
                ST_START: begin
                    r_state   <= ST_DATA;
                    r_bit_idx <= 3'd0;
                    r_tx      <= r_shift[0];
                end
                ST_DATA: begin
                    r_shift  <= {1'b0, r_shift[7:1]};
                    r_parity <= r_parity ^ r_shift[0];
                    if (!w_last_data) begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_tx      <= r_shift[1];
                    end else if (r_p[1]) begin
                        r_state <= ST_PARITY;
                        r_tx    <= r_parity ^ r_shift[0] ^ r_p[0];
                    end else begin
                        r_state       <= ST_STOP;
                        r_second_stop <= 1'b0;
                        r_tx          <= 1'b1;
                    end
                end
                ST_PARITY: begin
                    r_state       <= ST_STOP;
                    r_second_stop <= 1'b0;
                    r_tx          <= 1'b1;
                end
                ST_STOP: begin
                    if (w_last_stop) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_second_stop <= 1'b1;
                    end
                    r_tx <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o   = w_ready;
    assign uart_tx_o = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_tx_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_frontend
//  Purpose  : Directed scoreboard bench for tx_frontend.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_frontend;

    logic        clk;
    logic        rst;
    logic [15:0] cr_clk_div;
    logic        cr_ds;
    logic [1:0]  cr_p;
    logic        cr_s;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        uart_tx;

    int n_tests = 0;
    int n_fail  = 0;

    // Each entry: {expected uart_tx, expected ready} for one clock cycle.
    logic [1:0] exp_q[$];

    tx_frontend dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cr_clk_div_i (cr_clk_div),
        .cr_ds_i      (cr_ds),
        .cr_p_i       (cr_p),
        .cr_s_i       (cr_s),
        .data_i       (data),
        .valid_i      (valid),
        .ready_o      (ready),
        .uart_tx_o    (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(2'b11);
    endtask

    // Independent frame model: builds the bit list, then expands each bit to div cycles.
    task automatic push_frame(input logic [7:0] d, input int div, input logic ds,
                              input logic [1:0] p, input logic s);
        logic bits[$];
        int   nd;
        int   ones;
        int   eff;
        int   total;
        int   k;
        nd   = ds ? 7 : 8;
        eff  = (div == 0) ? 1 : div;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (p == 2'b10) bits.push_back((ones % 2) == 1);
        if (p == 2'b11) bits.push_back((ones % 2) == 0);
        bits.push_back(1'b1);
        if (s) bits.push_back(1'b1);
        total = bits.size() * eff;
        k = 0;
        foreach (bits[b]) begin
            for (int c = 0; c < eff; c++) begin
                k++;
                exp_q.push_back({bits[b], (k == total)});
            end
        end
    endtask

    task automatic check_cycles(input string tag, input int n);
        logic [1:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL %s scoreboard empty at cycle %0d", tag, i);
            end else begin
                e = exp_q.pop_front();
                n_tests++;
                assert (uart_tx === e[1]) else begin
                    n_fail++;
                    $error("FAIL %s tx cycle %0d: got %b want %b", tag, i + 1, uart_tx, e[1]);
                end
                n_tests++;
                assert (ready === e[0]) else begin
                    n_fail++;
                    $error("FAIL %s ready cycle %0d: got %b want %b", tag, i + 1, ready, e[0]);
                end
            end
        end
    endtask

    task automatic send(input string tag, input logic [7:0] d, input int div,
                        input logic ds, input logic [1:0] p, input logic s, input int len);
        data       = d;
        cr_clk_div = div[15:0];
        cr_ds      = ds;
        cr_p       = p;
        cr_s       = s;
        valid      = 1'b1;
        push_frame(d, div, ds, p, s);
        push_idle(3);
        @(posedge clk);
        #1 valid = 1'b0;
        check_cycles(tag, len + 3);
    endtask

    initial begin
        rst        = 1'b1;
        valid      = 1'b0;
        data       = 8'h00;
        cr_clk_div = 16'd4;
        cr_ds      = 1'b0;
        cr_p       = 2'b00;
        cr_s       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        push_idle(100);
        check_cycles("idle", 100);

        send("8N1_55", 8'h55, 4, 1'b0, 2'b00, 1'b0, 40);
        send("7E2_C1", 8'hC1, 2, 1'b1, 2'b10, 1'b1, 22);
        send("8O1_FF", 8'hFF, 3, 1'b0, 2'b11, 1'b0, 33);
        send("div0_8E1_3A", 8'h3A, 0, 1'b0, 2'b10, 1'b0, 11);
        send("div1_7O2_5B", 8'h5B, 1, 1'b1, 2'b11, 1'b1, 11);

        // Back-to-back: second word waits on valid; divider changes after first acceptance.
        @(negedge clk);
        data       = 8'h00;
        cr_clk_div = 16'd5;
        cr_ds      = 1'b0;
        cr_p       = 2'b00;
        cr_s       = 1'b0;
        valid      = 1'b1;
        push_frame(8'h00, 5, 1'b0, 2'b00, 1'b0);
        push_frame(8'hA5, 9, 1'b0, 2'b00, 1'b0);
        push_idle(2);
        @(posedge clk);
        #1;
        data       = 8'hA5;
        cr_clk_div = 16'd9;
        check_cycles("b2b_first", 50);
        @(posedge clk);
        #1 valid = 1'b0;
        check_cycles("b2b_second", 92);

        // Reset during DATA bit 3 (cycles 33..40 at div 8).
        @(negedge clk);
        data       = 8'h3C;
        cr_clk_div = 16'd8;
        valid      = 1'b1;
        push_frame(8'h3C, 8, 1'b0, 2'b00, 1'b0);
        @(posedge clk);
        #1 valid = 1'b0;
        check_cycles("pre_reset", 35);
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        push_idle(3);
        check_cycles("post_reset", 3);
        send("after_reset_8E2_96", 8'h96, 8, 1'b0, 2'b10, 1'b1, 96);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_frontend.md
# tx_frontend

UART transmit front end: serialises one data word into an asynchronous frame on `uart_tx_o`. The frame is start bit, 7 or 8 data bits LSB first, optional parity, and 1 or 2 stop bits. It is the counterpart of the receive front end and is driven by the same control-register fields (clock divider, data size, parity, stop bits). Upstream logic, i.e. the Wishbone register/FIFO side, hands words in through a valid/ready handshake.

## Interface
Parameters: none.

Ports:
- `clk_i`  in  1  single system clock; all logic rising-edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `cr_clk_div_i`  in  16  bit period in `clk_i` cycles; 0 is treated as 1.
- `cr_ds_i`  in  1  data size: 0 = 8 data bits, 1 = 7 data bits.
- `cr_p_i`  in  2  parity: 00/01 = none, 10 = even, 11 = odd.
- `cr_s_i`  in  1  stop bits: 0 = one, 1 = two.
- `data_i`  in  8  word to send; bit 7 is ignored in 7-bit mode.
- `valid_i`  in  1  `data_i` valid.
- `ready_o`  out  1  block can accept a word this cycle.
- `uart_tx_o`  out  1  serial line, idle high; registered.

## Operation
- States:
  - IDLE: line high.
  - START: line 0.
  - DATA: data bits, LSB first.
  - PARITY: the parity bit.
  - STOP: line 1, for one or two bit periods.
- Acceptance: a word is accepted when `valid_i && ready_o` on a rising edge.
  - On acceptance, `data_i`, `cr_clk_div_i`, `cr_ds_i`, `cr_p_i` and `cr_s_i` are latched.
  - Changes to the `cr_*` inputs mid-frame have no effect until the next acceptance.
- `ready_o` is high in IDLE. It is also high in the final cycle of the last stop bit, so frames can be sent back-to-back with no idle gap. It is low in all other cycles.
- Transitions:
  - IDLE → START on acceptance.
  - START → DATA after one bit period.
  - DATA → PARITY, or → STOP if no parity, after 8 (or 7) bit periods.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after one or two bit periods.
  - STOP → START instead, if a word is accepted in the final stop cycle.
- Parity:
  - Computed over the transmitted data bits only: bits [7:0] in 8-bit mode, bits [6:0] in 7-bit mode.
  - Even: the parity bit makes the total count of ones even. Odd: it makes the count odd.
- Bit timer:
  - Loaded with (effective div − 1) at the start of every bit.
  - Decrements every cycle.
  - The bit ends in the cycle the timer reads 0.
  - Every bit therefore lasts exactly effective-div cycles, with effective div in 1..65535.
- Data shift register and bit index:
  - The shift register shifts right at each DATA bit end.
  - A 3-bit bit index counts the DATA bits.
- `valid_i` while `ready_o` is low is ignored: no capture and no error. Upstream holds `data_i`/`valid_i` until the handshake.

## Timing
- Reset values: `uart_tx_o` = 1, `ready_o` = 1, state = IDLE, timer = 0, shift register = 0.
- Reset asserted mid-frame: the frame is aborted. The line is high and `ready_o` = 1 from the cycle after the reset edge. No partial frame resumes.
- Latency:
  - A word accepted at edge N puts the start bit (`uart_tx_o` = 0) on the line from edge N+1.
  - Each subsequent bit changes exactly effective-div cycles later.
- Frame length = (1 + D + P + S) × div cycles, where D ∈ {7, 8}, P ∈ {0, 1}, S ∈ {1, 2}.
- Back-to-back frames: the new start bit begins on the edge immediately after the last stop-bit cycle. The stop bit is not shortened and there is no extra idle cycle.
- div = 1 or div = 0: one cycle per bit. `ready_o` is high only in the single cycle of the last stop bit.

## Structure
- Shared package `uart_pkg`, also used by the receive front end:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - parity encodings (`PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD`);
  - data-size and stop-bit encodings.
- One natural sub-module, `baud_timer`:
  - a 16-bit down-counter;
  - inputs: load, load value, enable;
  - output: `tick_o` asserted in the cycle the count is 0.
  - The receive side can reuse it.
- Everything else lives in `tx_frontend`: state register, shift register, bit index, parity accumulator and output register.

## Test plan
- Reset then idle: hold `valid_i` = 0 for 100 cycles → `uart_tx_o` = 1 and `ready_o` = 1 throughout.
- 8N1 framing: div = 4, send 0x55.
  - Line carries 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total.
  - `ready_o` is high only in cycle 40, then stays high.
- 7E2 framing: div = 2, `cr_ds_i` = 1, send 0xC1.
  - Bit 7 is ignored; the data bits are 1,0,0,0,0,0,1.
  - Line carries 0, those seven data bits, parity 0, then 1,1. That is 11 bits, 22 cycles.
- 8O1 framing: div = 3, send 0xFF → eight data ones followed by parity bit 1, then one stop bit. 33 cycles total.
- Back-to-back: div = 5, keep `valid_i` high with 0x00 then 0xA5.
  - The second start bit begins on the edge right after the first frame's 5-cycle stop bit. No idle gap.
  - `cr_clk_div_i` changed to 9 mid-frame does not alter the first frame.
- Reset mid-frame: pulse `rst_i` during the DATA bit 3 of a div = 8 frame.
  - Next cycle: `uart_tx_o` = 1, `ready_o` = 1.
  - A new word then transmits a complete, correct frame.
